// File: rtl/record_instrument.sv
// record_instrument: packs 8-bit mic PCM samples four per 36-bit ZBT word and writes one take to a contiguous ZBT region.
// Latency: the 4th ready of a word at cycle N gives we_ZBT=0 in cycle N+1; recording rises 2 cycles after record rises.
// Backpressure: none; ZBT write takes one cycle and readies are >=8 cycles apart. Optional macro RECORD_MONITOR_EN enables the headphone monitor path.
module record_instrument #(
  parameter int RECORDING_LEN = 32768,
  parameter int ADDR_W        = 19
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_record,
  input  logic              i_ready,
  input  logic [ADDR_W-1:0] i_base_address,
  input  logic [7:0]        i_from_ac97_data,
  output logic              o_we_ZBT,
  output logic [ADDR_W-1:0] o_address,
  output logic [35:0]       o_data_out,
  output logic              o_recording,
  output logic              o_done,
  output logic [19:0]       o_words_written,
  output logic [7:0]        o_to_ac97_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RECORD = 3'd1,
    S_WRITE  = 3'd2,
    S_FLUSH  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [19:0]       LEN_W    = 20'(RECORDING_LEN);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Current-state registers.
  state_t              r_state;
  logic                r_record_s;
  logic                r_record_q;
  logic [1:0]          r_lane;
  logic [31:0]         r_pack;
  logic                r_stop_pend;
  logic [ADDR_W-1:0]   r_address;
  logic [35:0]         r_data_out;
  logic                r_we;
  logic                r_recording;
  logic                r_done;
  logic [19:0]         r_words;

  // Next-state values from the combinational process.
  state_t              w_state_nxt;
  logic [1:0]          w_lane_nxt;
  logic [31:0]         w_pack_nxt;
  logic                w_stop_pend_nxt;
  logic [ADDR_W-1:0]   w_address_nxt;
  logic [35:0]         w_data_nxt;
  logic [19:0]         w_words_nxt;

  // Helper wires.
  logic                w_start;
  logic                w_stop;
  logic [31:0]         w_sample_pack;
  logic [19:0]         w_words_inc;
  logic                w_last_word;
  logic                w_write_nxt;

  // The record level is sampled once before edge detection so that a start
  // and its matching stop are both seen one cycle after the pin moves.
  assign w_start     = r_record_s & ~r_record_q;
  assign w_stop      = ~r_record_s & r_record_q;
  assign w_words_inc = r_words + 20'd1;
  assign w_last_word = (w_words_inc == LEN_W);

  // Merge the incoming sample into the lane it belongs to (sample 0 lowest).
  always_comb begin
    w_sample_pack = r_pack;
    w_sample_pack[{r_lane, 3'b000} +: 8] = i_from_ac97_data;
  end

  // Record-level synchroniser and edge-detect history.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_record_s <= 1'b0;
      r_record_q <= 1'b0;
    end else begin
      r_record_s <= i_record;
      r_record_q <= r_record_s;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_lane_nxt      = r_lane;
    w_pack_nxt      = r_pack;
    w_stop_pend_nxt = r_stop_pend;
    w_address_nxt   = r_address;
    w_data_nxt      = r_data_out;
    w_words_nxt     = r_words;

    case (r_state)
      S_IDLE, S_DONE: begin
        // Only a fresh rising edge starts a take; a held level does nothing.
        if (w_start) begin
          w_state_nxt     = S_RECORD;
          w_address_nxt   = i_base_address;
          w_lane_nxt      = 2'd0;
          w_pack_nxt      = 32'd0;
          w_words_nxt     = 20'd0;
          w_stop_pend_nxt = 1'b0;
        end
      end

      S_RECORD: begin
        if (i_ready) begin
          w_pack_nxt = w_sample_pack;
          w_lane_nxt = r_lane + 2'd1;
        end
        if (i_ready && (r_lane == 2'd3)) begin
          // Word complete; a coincident stop is remembered and honoured after the write.
          w_state_nxt     = S_WRITE;
          w_data_nxt      = {4'h0, w_sample_pack};
          w_stop_pend_nxt = w_stop;
        end else if (w_stop) begin
          if ((r_lane == 2'd0) && !i_ready) begin
            // Nothing buffered: end the take without a write.
            w_state_nxt = S_DONE;
          end else begin
            // Partial word: unfilled lanes are already zero in the pack register.
            w_state_nxt = S_FLUSH;
            w_data_nxt  = {4'h0, (i_ready ? w_sample_pack : r_pack)};
          end
        end
      end

      S_WRITE: begin
        w_address_nxt   = r_address + ADDR_ONE;
        w_words_nxt     = w_words_inc;
        w_pack_nxt      = 32'd0;
        w_lane_nxt      = 2'd0;
        w_stop_pend_nxt = 1'b0;
        if (w_last_word || r_stop_pend || w_stop) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RECORD;
        end
      end

      S_FLUSH: begin
        w_address_nxt   = r_address + ADDR_ONE;
        w_words_nxt     = w_words_inc;
        w_pack_nxt      = 32'd0;
        w_lane_nxt      = 2'd0;
        w_stop_pend_nxt = 1'b0;
        w_state_nxt     = S_DONE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_write_nxt = (w_state_nxt == S_WRITE) || (w_state_nxt == S_FLUSH);

  // State, datapath and registered status outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_lane      <= 2'd0;
      r_pack      <= 32'd0;
      r_stop_pend <= 1'b0;
      r_address   <= '0;
      r_data_out  <= 36'd0;
      r_we        <= 1'b1;
      r_recording <= 1'b0;
      r_done      <= 1'b0;
      r_words     <= 20'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_lane      <= w_lane_nxt;
      r_pack      <= w_pack_nxt;
      r_stop_pend <= w_stop_pend_nxt;
      r_address   <= w_address_nxt;
      r_data_out  <= w_data_nxt;
      r_we        <= ~w_write_nxt;
      r_recording <= (w_state_nxt == S_RECORD) || w_write_nxt;
      r_done      <= (w_state_nxt == S_DONE);
      r_words     <= w_words_nxt;
    end
  end

  assign o_we_ZBT        = r_we;
  assign o_address       = r_address;
  assign o_data_out      = r_data_out;
  assign o_recording     = r_recording;
  assign o_done          = r_done;
  assign o_words_written = r_words;

`ifdef RECORD_MONITOR_EN
  logic [7:0] r_monitor;

  // Live headphone monitor: echo each mic sample while a take is running.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_monitor <= 8'd0;
    end else if (!r_recording) begin
      r_monitor <= 8'd0;
    end else if (i_ready) begin
      r_monitor <= i_from_ac97_data;
    end
  end

  assign o_to_ac97_data = r_monitor;
`else
  assign o_to_ac97_data = 8'd0;
`endif

endmodule

// File: tb/tb_record_instrument.sv
// Directed bench for record_instrument (RECORDING_LEN=4 so the length limit is reachable).
// Writes are logged from the ZBT port each cycle; checks compare against hand-computed words.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_record_instrument;
  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic          rec;
  logic          rdy;
  logic [AW-1:0] base;
  logic [7:0]    din;
  logic          we;
  logic [AW-1:0] addr;
  logic [35:0]   dout;
  logic          recording;
  logic          done;
  logic [19:0]   ww;
  logic [7:0]    mon;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [35:0]   d;
  } wr_t;
  wr_t wq[$];
  int  run_len = 0;
  int  max_run = 0;
  int  w0;

  always #5 clk = ~clk;

  record_instrument #(.RECORDING_LEN(4), .ADDR_W(AW)) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_record        (rec),
    .i_ready         (rdy),
    .i_base_address  (base),
    .i_from_ac97_data(din),
    .o_we_ZBT        (we),
    .o_address       (addr),
    .o_data_out      (dout),
    .o_recording     (recording),
    .o_done          (done),
    .o_words_written (ww),
    .o_to_ac97_data  (mon)
  );

  // Log every ZBT write and the longest run of consecutive write cycles.
  always @(negedge clk) begin
    if (we === 1'b0) begin
      wq.push_back({addr, dout});
      run_len = run_len + 1;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rdy = 1'b1;
    din = b;
    @(negedge clk);
    rdy = 1'b0;
    cyc(7);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"},   64'(we),        64'd1);
    chk({tag, "_addr"}, 64'(addr),      64'd0);
    chk({tag, "_data"}, 64'(dout),      64'd0);
    chk({tag, "_rec"},  64'(recording), 64'd0);
    chk({tag, "_done"}, 64'(done),      64'd0);
    chk({tag, "_ww"},   64'(ww),        64'd0);
    chk({tag, "_mon"},  64'(mon),       64'd0);
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [AW-1:0] ea, input logic [35:0] ed);
    chk({tag, "_addr"}, 64'(wq[idx].a), 64'(ea));
    chk({tag, "_data"}, 64'(wq[idx].d), 64'(ed));
  endtask

  initial begin
    rst  = 1'b1;
    rec  = 1'b0;
    rdy  = 1'b0;
    base = '0;
    din  = 8'd0;
    cyc(3);
    chk_reset_vals("reset");
    rst = 1'b0;
    cyc(2);

    // Take 1: two full words, stop on a word boundary, no flush.
    w0   = wq.size();
    base = 19'h00100;
    rec  = 1'b1;
    cyc(1);
    chk("t1_rec_early", 64'(recording), 64'd0);
    cyc(1);
    chk("t1_rec_rise", 64'(recording), 64'd1);
    send(8'h01); send(8'h02); send(8'h03);
    rdy = 1'b1;
    din = 8'h04;
    @(negedge clk);
    rdy = 1'b0;
    chk("t1_lat_we",   64'(we),   64'd0);
    chk("t1_lat_addr", 64'(addr), 64'h00100);
    chk("t1_lat_data", 64'(dout), 64'h004030201);
    @(negedge clk);
    chk("t1_post_we",   64'(we),   64'd1);
    chk("t1_post_addr", 64'(addr), 64'h00101);
    cyc(6);
    send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    rec = 1'b0;
    cyc(4);
    chk("t1_nwr",  64'(wq.size() - w0), 64'd2);
    chk_wr("t1_w0", w0,     19'h00100, 36'h004030201);
    chk_wr("t1_w1", w0 + 1, 19'h00101, 36'h008070605);
    chk("t1_ww",   64'(ww),        64'd2);
    chk("t1_done", 64'(done),      64'd1);
    chk("t1_rec",  64'(recording), 64'd0);
    chk("t1_addr", 64'(addr),      64'h00102);

    // Take 2: six samples then stop -> one full word plus a flushed partial word.
    w0   = wq.size();
    base = 19'h00200;
    rec  = 1'b1;
    cyc(2);
    chk("t2_done_clr", 64'(done), 64'd0);
    send(8'h11); send(8'h12); send(8'h13); send(8'h14); send(8'h15); send(8'h16);
    rec = 1'b0;
    cyc(4);
    chk("t2_nwr", 64'(wq.size() - w0), 64'd2);
    chk_wr("t2_w0", w0,     19'h00200, 36'h014131211);
    chk_wr("t2_fl", w0 + 1, 19'h00201, 36'h000001615);
    chk("t2_ww",   64'(ww),   64'd2);
    chk("t2_done", 64'(done), 64'd1);

    // Take 3: record held high, length limit of 4 words reached, extra readies ignored.
    w0   = wq.size();
    base = 19'h00300;
    rec  = 1'b1;
    cyc(2);
    for (int i = 1; i <= 15; i++) send(8'(i));
    chk("t3_done_15", 64'(done), 64'd0);
    send(8'd16);
    chk("t3_done_16", 64'(done),      64'd1);
    chk("t3_rec_16",  64'(recording), 64'd0);
    chk("t3_ww_16",   64'(ww),        64'd4);
    for (int i = 17; i <= 20; i++) send(8'(i));
    chk("t3_nwr", 64'(wq.size() - w0), 64'd4);
    chk_wr("t3_w0", w0,     19'h00300, 36'h004030201);
    chk_wr("t3_w1", w0 + 1, 19'h00301, 36'h008070605);
    chk_wr("t3_w2", w0 + 2, 19'h00302, 36'h00c0b0a09);
    chk_wr("t3_w3", w0 + 3, 19'h00303, 36'h0100f0e0d);
    chk("t3_ww", 64'(ww), 64'd4);
    rec = 1'b0;
    cyc(3);
    chk("t3_done_hold", 64'(done), 64'd1);

    // Take 4: address wraps from the top of the ZBT to zero.
    w0   = wq.size();
    base = 19'h7FFFF;
    rec  = 1'b1;
    cyc(2);
    send(8'h31); send(8'h32); send(8'h33); send(8'h34);
    send(8'h35); send(8'h36); send(8'h37); send(8'h38);
    rec = 1'b0;
    cyc(4);
    chk("t4_nwr", 64'(wq.size() - w0), 64'd2);
    chk_wr("t4_w0", w0,     19'h7FFFF, 36'h034333231);
    chk_wr("t4_w1", w0 + 1, 19'h00000, 36'h038373635);
    chk("t4_addr", 64'(addr), 64'h00001);
    chk("t4_ww",   64'(ww),   64'd2);

    // Take 5: reset after three samples discards them; the next take starts at lane 0.
    w0   = wq.size();
    base = 19'h00400;
    rec  = 1'b1;
    cyc(2);
    send(8'h41); send(8'h42); send(8'h43);
    rst = 1'b1;
    rec = 1'b0;
    @(negedge clk);
    chk_reset_vals("t5_rst");
    cyc(1);
    rst = 1'b0;
    cyc(3);
    chk("t5_nowr", 64'(wq.size() - w0), 64'd0);
    base = 19'h00500;
    rec  = 1'b1;
    cyc(2);
    send(8'h51); send(8'h52); send(8'h53); send(8'h54);
    rec = 1'b0;
    cyc(4);
    chk("t5_nwr", 64'(wq.size() - w0), 64'd1);
    chk_wr("t5_w0", w0, 19'h00500, 36'h054535251);
    chk("t5_ww",   64'(ww),   64'd1);
    chk("t5_done", 64'(done), 64'd1);

    // Take 6: single sample, monitor output, then a one-lane flush.
    w0   = wq.size();
    base = 19'h00600;
    rec  = 1'b1;
    cyc(2);
    rdy = 1'b1;
    din = 8'hA5;
    @(negedge clk);
    rdy = 1'b0;
`ifdef RECORD_MONITOR_EN
    chk("t6_mon_live", 64'(mon), 64'hA5);
`else
    chk("t6_mon_live", 64'(mon), 64'h00);
`endif
    cyc(3);
    rec = 1'b0;
    cyc(5);
    chk("t6_nwr", 64'(wq.size() - w0), 64'd1);
    chk_wr("t6_fl", w0, 19'h00600, 36'h0000000A5);
    chk("t6_done",     64'(done), 64'd1);
    chk("t6_ww",       64'(ww),   64'd1);
    chk("t6_mon_idle", 64'(mon),  64'h00);

    chk("we_pulse_len", 64'(max_run),   64'd1);
    chk("total_writes", 64'(wq.size()), 64'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/record_instrument.md
# record_instrument

Capture stage directly upstream of the ZBT-based instrument playback loop. Packs 8-bit PCM samples from the AC97 mic path into 36-bit ZBT words, four samples per word, and writes them to a contiguous ZBT region starting at a base address. Reports the number of words written so the playback stage can loop over exactly the recorded take.

## Interface
- RECORDING_LEN, 32768: maximum words per take; capture stops automatically at this count.
- ADDR_W, 19: ZBT address width.
- clock  in  1  27 MHz system clock; only clock domain.
- reset  in  1  synchronous, active-high; returns block to IDLE.
- record  in  1  level; a rising edge starts a take, a falling edge ends it early.
- ready  in  1  one-cycle strobe, AC97 sample valid; strobes are at least 8 cycles apart.
- base_address  in  ADDR_W  first ZBT word of the take; sampled on the start edge.
- from_ac97_data  in  8  mic PCM sample, valid when ready=1.
- we_ZBT  out  1  ZBT write enable, active-low (0 = write, 1 = idle/read).
- address  out  ADDR_W  ZBT word address.
- data_out  out  36  ZBT write data.
- recording  out  1  high in RECORD, WRITE and FLUSH.
- done  out  1  high in DONE.
- words_written  out  20  words committed in the current/last take.
- to_ac97_data  out  8  headphone monitor sample (see Configuration).

## Operation
- States: IDLE, RECORD, WRITE, FLUSH, DONE.
- record edge detection: registered copy record_q; start = record & ~record_q, stop = ~record & record_q.
- IDLE: on start -> RECORD; address <= base_address, lane <= 0, words_written <= 0, pack register cleared.
- RECORD: on ready, pack[8*lane+7 : 8*lane] <= from_ac97_data, lane <= lane+1 (2-bit, wraps). On the 4th sample (lane==3 with ready) -> WRITE.
- Word layout: sample k of the word (k=0 first in time) in bits [8k+7:8k]; bits [35:32] = 0.
- WRITE: exactly one cycle; we_ZBT=0, data_out=pack, address=current word. Next state: DONE if words_written+1 == RECORDING_LEN or stop is pending; else RECORD. On exit address <= address+1 (wraps modulo 2^ADDR_W), words_written <= words_written+1, pack cleared.
- stop in RECORD: if lane==0 -> DONE directly; else -> FLUSH.
- FLUSH: one cycle; behaves exactly as WRITE with the partial word (unfilled lanes zero), then DONE.
- stop arriving in same cycle as a 4th-sample ready: sample captured, WRITE taken, stop latched as pending, then DONE.
- ready in WRITE/FLUSH/DONE/IDLE: ignored.
- DONE: done=1, words_written held, address held at last+1; start -> same as IDLE start. record held high into DONE does not restart (edge only).
- reset mid-take: any partially packed samples discarded; no write issued.

## Timing
- Reset values: we_ZBT=1, address=0, data_out=0, recording=0, done=0, words_written=0, to_ac97_data=0, state IDLE.
- All outputs registered.
- Latency: 4th ready at cycle N -> we_ZBT=0 with valid address/data during cycle N+1 -> we_ZBT=1, address incremented at N+2.
- we_ZBT low for exactly one cycle per word; data_out and address stable throughout that cycle.
- recording rises the cycle after the start edge is registered (2 cycles after record rises); done rises the cycle after the final WRITE/FLUSH.

## Configuration
- RECORD_MONITOR_EN defined: to_ac97_data <= from_ac97_data on every ready while recording=1, else 0 (live monitoring, 1-cycle latency).
- Undefined: to_ac97_data constant 0; no monitor logic synthesized.

## Test plan
- Start at base 0x00100, 8 readies with samples 0x01..0x08, then drop record -> two writes: addr 0x00100 data 0x0_04030201, addr 0x00101 data 0x0_08070605; words_written=2, done=1, no FLUSH write.
- 6 samples 0x11..0x16, drop record -> writes 0x0_14131211 then FLUSH 0x0_00001615; words_written=2.
- RECORDING_LEN=4, record held high, 20 readies -> exactly 4 writes at base..base+3, done=1 after 16th sample, readies 17-20 ignored, words_written=4.
- base 0x7FFFF, 8 samples -> writes at 0x7FFFF then 0x00000 (wrap).
- reset asserted after 3 samples -> no write ever, all outputs at reset values next cycle; new start edge records from lane 0.
- RECORD_MONITOR_EN defined, sample 0xA5 while recording -> to_ac97_data=0xA5 one cycle after ready; in IDLE -> 0.
